// File: rtl/output_record_arbiter.sv
// Merges hit, register-readback and service record sources into one single-slot
// record stream, keeping multi-record frames contiguous and guaranteeing hit progress.
//
// state    | meaning
// UNLOCKED | arbitrate among all valid sources on each free slot
// LOCKED   | only lock_src may load until its last record is taken
module output_record_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [71:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ack,
    output logic        emptyFifo,
    output logic [23:0] data,
    input  logic        readFifo,
    output logic [2:0]  grant,
    output logic        hdrErr
);

    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
    localparam logic [7:0] HIT_HDR = 8'hE9;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lock_src_q, lock_src_d;
    logic        out_valid_q, out_valid_d;
    logic [23:0] data_q, data_d;
    logic [3:0]  starve_q, starve_d;
    logic        hdr_err_q, hdr_err_d;
    logic [2:0]  grant_q, grant_d;

    logic        slot_free;
    logic        take;
    logic [1:0]  win;
    logic        win_last;
    logic [23:0] win_data;

    always_comb begin
        state_d     = state_q;
        lock_src_d  = lock_src_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        starve_d    = starve_q;
        hdr_err_d   = hdr_err_q;
        grant_d     = grant_q;
        take        = 1'b0;
        win         = 2'd0;
        win_last    = 1'b0;
        win_data    = 24'd0;
        req_ack     = 3'b000;

        slot_free = !out_valid_q || readFifo;

        if (state_q == UNLOCKED) begin
            take = slot_free && (|req_valid);
            // Starved hit data overrides the fixed register > service > hit order.
            if (starve_q == LIMIT && req_valid[0]) begin
                win = 2'd0;
            end else if (req_valid[1]) begin
                win = 2'd1;
            end else if (req_valid[2]) begin
                win = 2'd2;
            end else begin
                win = 2'd0;
            end
        end else begin
            win  = lock_src_q;
            take = slot_free && req_valid[lock_src_q];
        end

        case (win)
            2'd1:    begin win_data = req_data[47:24]; win_last = req_last[1]; end
            2'd2:    begin win_data = req_data[71:48]; win_last = req_last[2]; end
            default: begin win_data = req_data[23:0];  win_last = req_last[0]; end
        endcase

        if (take) begin
            req_ack     = 3'b001 << win;
            out_valid_d = 1'b1;
            data_d      = win_data;
            if (win == 2'd0) begin
                starve_d = 4'd0;
                if (state_q == UNLOCKED && win_data[23:16] != HIT_HDR) begin
                    hdr_err_d = 1'b1;
                end
            end else if (state_q == UNLOCKED && req_valid[0] && starve_q != LIMIT) begin
                starve_d = starve_q + 4'd1;
            end

            if (state_q == UNLOCKED && !win_last) begin
                state_d    = LOCKED;
                lock_src_d = win;
                grant_d    = 3'b001 << win;
            end else if (state_q == LOCKED && win_last) begin
                state_d = UNLOCKED;
                grant_d = 3'b000;
            end
        end else if (readFifo) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNLOCKED;
            lock_src_q  <= 2'd0;
            out_valid_q <= 1'b0;
            data_q      <= 24'd0;
            starve_q    <= 4'd0;
            hdr_err_q   <= 1'b0;
            grant_q     <= 3'b000;
        end else begin
            state_q     <= state_d;
            lock_src_q  <= lock_src_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            starve_q    <= starve_d;
            hdr_err_q   <= hdr_err_d;
            grant_q     <= grant_d;
        end
    end

    assign emptyFifo = !out_valid_q;
    assign data      = data_q;
    assign grant     = grant_q;
    assign hdrErr    = hdr_err_q;

endmodule

// File: tb/tb_output_record_arbiter.sv
// Directed and randomized checks of output_record_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_output_record_arbiter;

    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [71:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ack;
    logic        emptyFifo;
    logic [23:0] data;
    logic        readFifo;
    logic [2:0]  grant;
    logic        hdrErr;

    output_record_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .emptyFifo(emptyFifo), .data(data),
        .readFifo(readFifo), .grant(grant), .hdrErr(hdrErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source queues: {last, record}
    logic [24:0] src_q [3][$];
    bit          pres [3];
    bit          rand_gate = 0;
    int          ack_log [$];

    // Reference model state
    bit          m_valid;
    logic [23:0] m_data;
    int          m_lock;
    int          m_starve;
    bit          m_hdr;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 3; i++) begin
            src_q[i].delete();
            pres[i] = 0;
        end
    endtask

    task automatic do_reset();
        clear_sources();
        reset = 1'b1;
        req_valid = 3'b000;
        req_data = 72'd0;
        req_last = 3'b000;
        readFifo = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_valid = 0; m_data = 24'd0; m_lock = -1; m_starve = 0; m_hdr = 0;
        chk("rst_empty", 24'(emptyFifo), 24'd1);
        chk("rst_grant", 24'(grant), 24'd0);
        chk("rst_hdr", 24'(hdrErr), 24'd0);
        chk("rst_data", data, 24'd0);
        @(negedge clk);
    endtask

    task automatic cycle(input logic rd);
        logic [2:0]  v;
        logic [2:0]  l;
        logic [23:0] d [3];
        int          win;
        logic [2:0]  exp_ack;
        logic [24:0] head;
        for (int i = 0; i < 3; i++) begin
            if (!pres[i] && src_q[i].size() > 0 && (!rand_gate || $urandom_range(0, 3) != 0))
                pres[i] = 1;
            v[i] = pres[i];
            if (pres[i]) begin
                head = src_q[i][0];
                d[i] = head[23:0];
                l[i] = head[24];
            end else begin
                d[i] = 24'd0;
                l[i] = 1'b0;
            end
        end
        req_valid = v;
        req_last  = l;
        req_data  = {d[2], d[1], d[0]};
        readFifo  = rd;

        win = -1;
        if (!m_valid || rd) begin
            if (m_lock < 0) begin
                if (v != 3'b000) begin
                    if (m_starve == LIM && v[0]) win = 0;
                    else if (v[1]) win = 1;
                    else if (v[2]) win = 2;
                    else win = 0;
                end
            end else if (v[m_lock]) begin
                win = m_lock;
            end
        end
        exp_ack = (win >= 0) ? 3'(1 << win) : 3'b000;
        #1;
        chk("req_ack", 24'(req_ack), 24'(exp_ack));

        @(posedge clk); #1;
        if (win >= 0) begin
            m_data = d[win];
            m_valid = 1;
            if (win == 0) begin
                if (m_lock < 0 && d[0][23:16] != 8'hE9) m_hdr = 1;
                m_starve = 0;
            end else if (m_lock < 0 && v[0]) begin
                m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
            end
            if (m_lock < 0) begin
                if (!l[win]) m_lock = win;
            end else if (l[win]) begin
                m_lock = -1;
            end
            void'(src_q[win].pop_front());
            pres[win] = 0;
            ack_log.push_back(win);
        end else if (rd) begin
            m_valid = 0;
        end

        chk("emptyFifo", 24'(emptyFifo), 24'(!m_valid));
        if (m_valid) chk("data", data, m_data);
        chk("grant", 24'(grant), (m_lock < 0) ? 24'd0 : 24'(1 << m_lock));
        chk("hdrErr", 24'(hdrErr), 24'(m_hdr));
        @(negedge clk);
    endtask

    task automatic push_frame(input int src, input int len, input logic [7:0] hdr);
        logic [23:0] rec;
        for (int k = 0; k < len; k++) begin
            rec = 24'($urandom);
            if (k == 0 && src == 0) rec[23:16] = hdr;
            src_q[src].push_back({(k == len - 1) ? 1'b1 : 1'b0, rec});
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Idle with a stray readFifo pulse.
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        chk("idle_empty", 24'(emptyFifo), 24'd1);

        // Hit frame with a register record arriving a cycle later.
        ack_log.delete();
        src_q[0].push_back({1'b0, 24'hE90001});
        src_q[0].push_back({1'b0, 24'h123456});
        src_q[0].push_back({1'b1, 24'h654321});
        cycle(1'b1);
        chk("hit_grant", 24'(grant), 24'h1);
        src_q[1].push_back({1'b1, 24'hEA0010});
        for (int i = 0; i < 5; i++) cycle(1'b1);
        chk("frame_cnt", 24'(ack_log.size()), 24'd4);
        chk("frame_o0", 24'(ack_log[0]), 24'd0);
        chk("frame_o1", 24'(ack_log[1]), 24'd0);
        chk("frame_o2", 24'(ack_log[2]), 24'd0);
        chk("frame_o3", 24'(ack_log[3]), 24'd1);
        chk("frame_last", data, 24'hEA0010);

        // Starvation: all sources continuously valid, consumer always reading.
        ack_log.delete();
        for (int i = 0; i < 10; i++) begin
            src_q[0].push_back({1'b1, 24'hE90000 | 24'(i)});
            src_q[1].push_back({1'b1, 24'hEA0000 | 24'(i)});
            src_q[2].push_back({1'b1, 24'hEB0000 | 24'(i)});
        end
        for (int i = 0; i < 8; i++) cycle(1'b1);
        chk("starve_cnt", 24'(ack_log.size()), 24'd8);
        for (int i = 0; i < 8; i++)
            chk("starve_seq", 24'(ack_log[i]), ((i % 4) == 3) ? 24'd0 : 24'd1);
        clear_sources();

        // Consumer stall with a service request pending.
        ack_log.delete();
        src_q[2].push_back({1'b1, 24'hEB0777});
        for (int i = 0; i < 5; i++) cycle(1'b0);
        chk("stall_noack", 24'(ack_log.size()), 24'd0);
        cycle(1'b1);
        chk("stall_load", 24'(ack_log.size()), 24'd1);
        chk("stall_data", data, 24'hEB0777);

        // Bad hit header is sticky across later good frames.
        src_q[0].push_back({1'b1, 24'hEF0000});
        cycle(1'b1);
        cycle(1'b1);
        chk("hdr_set", 24'(hdrErr), 24'd1);
        push_frame(0, 2, 8'hE9);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("hdr_sticky", 24'(hdrErr), 24'd1);

        // Reset in the middle of a locked frame.
        push_frame(0, 3, 8'hE9);
        cycle(1'b1);
        cycle(1'b1);
        chk("mid_lock", 24'(grant), 24'h1);
        do_reset();
        chk("mid_empty", 24'(emptyFifo), 24'd1);
        chk("mid_grant", 24'(grant), 24'd0);
        ack_log.delete();
        src_q[2].push_back({1'b1, 24'hEB1234});
        cycle(1'b1);
        chk("svc_after", 24'(ack_log.size()), 24'd1);
        chk("svc_data", data, 24'hEB1234);

        // Randomized traffic.
        rand_gate = 1;
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < 3; s++)
                if (src_q[s].size() < 4 && $urandom_range(0, 3) == 0)
                    push_frame(s, $urandom_range(1, 3),
                               ($urandom_range(0, 7) == 0) ? 8'(($urandom & 8'hFF) | 8'h01) : 8'hE9);
            cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_record_arbiter.md
# output_record_arbiter

Merges three 24-bit record sources into the single FIFO-style record stream consumed by the 8b10b output serializer path. The sources are hit-data frames, register readback records and service records. Multi-record frames are kept contiguous by locking the grant until the frame's last record. A saturating starvation counter guarantees hit data forward progress. The block sits between the record generators and the output serializer's `emptyFifo`/`data`/`readFifo` port.

## Interface
- `STARVE_LIMIT`, default 8: number of consecutive non-hit grants, while hit is waiting, after which hit data is forced to win one arbitration. Legal range 1–15.
- `clk`  in  1  record clock. The only clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  3  source has a record. Bit 0 = hit data, bit 1 = register readback, bit 2 = service.
- `req_data`  in  72  record per source; source i is on bits [24i+23:24i].
- `req_last`  in  3  record is the last of its frame. Single-record sources tie this high.
- `req_ack`  out  3  one-hot; the record of that source is taken at this rising edge.
- `emptyFifo`  out  1  high when no record is held for the consumer.
- `data`  out  24  held record. Valid only while `emptyFifo` is 0.
- `readFifo`  in  1  consumer pops the held record. Single-cycle pulse in the `clk` domain.
- `grant`  out  3  one-hot source currently holding the frame lock; 0 when unlocked.
- `hdrErr`  out  1  sticky: the first record of a hit frame did not carry header byte 8'hE9.

## Operation
- Output holding register (`out_valid`, `data`):
  - `emptyFifo` = !`out_valid`.
  - Slot free = !`out_valid` || `readFifo`.
  - `readFifo` while empty is ignored.
- States:
  - **UNLOCKED**
    - If the slot is free and any `req_valid` is set: select a winner, load its `req_data` into `data`, set `out_valid`, pulse `req_ack[winner]`.
    - If the winner's `req_last`=0, go to LOCKED(winner). Otherwise stay in UNLOCKED.
  - **LOCKED(s)**
    - Only source s is considered; other requests wait regardless of priority.
    - When the slot is free and `req_valid[s]`: load, ack s. If `req_last[s]`=1, go to UNLOCKED.
    - If `req_valid[s]` is low, hold; no timeout.
- Priority in UNLOCKED:
  - Default order: register > service > hit.
  - If `starve_cnt` == `STARVE_LIMIT` and `req_valid[0]`, hit wins.
- `starve_cnt` (4 bit):
  - +1 (saturating at `STARVE_LIMIT`) on each UNLOCKED grant to source 1 or 2 while `req_valid[0]` is high.
  - Cleared on every grant to source 0.
  - Unchanged otherwise.
- `hdrErr`: set when source 0 is granted from UNLOCKED and `req_data[23:16]` != 8'hE9. Cleared only by reset.
- If the slot is free but no eligible request exists, `out_valid` is cleared on `readFifo` and `emptyFifo` rises.
- Reset values: `out_valid`=0 (`emptyFifo`=1), `data`=0, `req_ack`=0, `grant`=0, state UNLOCKED, `starve_cnt`=0, `hdrErr`=0.
- Reset mid-frame drops the held record and the lock. Sources must restart their frames.

## Timing
- `req_ack` is combinational from registered state plus `req_valid`/`req_last`/`readFifo`.
  - Sources must hold `req_valid`/`req_data`/`req_last` stable until acked.
  - Sources pop on the edge where `req_ack` is high.
- Latency: a record acked at edge N is on `data` with `emptyFifo`=0 from edge N onward (1 cycle after presentation when the slot is free).
- Throughput: `readFifo` and load in the same cycle gives back-to-back records, one per clock, with no bubble.
- `grant` updates on the same edge as the state change. It is high from the first record's ack edge through the last record's ack edge.
- Simultaneous requests in UNLOCKED are resolved in a single cycle.
- The lock transition and the next arbitration never take an extra idle cycle.

## Test plan
- Reset, then idle: `emptyFifo`=1, `grant`=0, `req_ack`=0. A `readFifo` pulse changes nothing.
- Hit frame E9_0001, 123456, 654321 (last) while a register record EA_0010 is pending from cycle 1:
  - the three hit records appear contiguously;
  - EA_0010 follows;
  - `grant`=001 throughout the hit frame.
- All three sources are single-record and continuously valid, with `STARVE_LIMIT`=3 and `readFifo` held high:
  - grant sequence is reg, reg, reg, hit, reg, …;
  - one record per clock.
- Consumer stalls (`readFifo`=0 for 5 cycles) with a request pending:
  - `data` is held;
  - no `req_ack`;
  - on `readFifo`=1, the new record loads the same edge.
- Hit frame starting with 8'hEF: `hdrErr` goes to 1 and stays high through later valid frames until reset.
- Reset asserted in LOCKED mid-frame: next cycle `emptyFifo`=1, `grant`=0. A service request is then granted immediately.
